alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Shares the single integer Alu between NUM_REQ requesters (fetch/decode, ray unit, ...).
//  - Round-robin arbitration; drives Alu operands; captures its combinational result.
//  - Division is not taken from Alu: it runs in an iterative divider, 1 quotient bit per cycle.
//  - Returns result + flags + requester id on a valid/ready response channel.
// PARAMETERS
//  NUM_REQ    2   number of requesters (2..8)
//  ID_W       1   width of resp_id, = clog2(NUM_REQ)
// PORTS
//  clk         in   1           system clock, all logic rising-edge
//  reset       in   1           synchronous, active-high
//  req_valid   in   NUM_REQ     request valid per requester
//  req_ready   out  NUM_REQ     one-hot grant/accept pulse
//  req_op      in   4*NUM_REQ   Alu op per requester (slice i = [4i+3:4i])
//  req_a       in   32*NUM_REQ  operand0 per requester
//  req_b       in   32*NUM_REQ  operand1 per requester
//  alu_op      out  4           to Alu op (int_float tied 0 at parent)
//  alu_a       out  32          to Alu operand0
//  alu_b       out  32          to Alu operand1
//  alu_res     in   32          from Alu res (combinational)
//  resp_valid  out  1           response valid
//  resp_ready  in   1           consumer accepts response
//  resp_id     out  ID_W        index of the requester served
//  resp_res    out  32          result
//  resp_zero   out  1           resp_res == 0
//  resp_neg    out  1           resp_res[31]
//  resp_nan    out  1           divide by zero
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - state=IDLE, rr_ptr=0; req_ready=0, resp_valid=0.
//    - resp_res/resp_id/alu_* = 0; all flags 0. Reset wins over every other event, mid-divide included.
//  - Ops: 0000 xor, 0001 and, 0010 or, 0011 a&~b, 0100 add, 0101 sub, 0110 mul (low 32),
//    0111 unsigned div, 1000 shl b[4:0], 1001 shr logical b[4:0], 1010-1111 add.
//  - FSM IDLE -> GRANT (no extra cycle) -> EXEC | DIV -> RESP -> IDLE.
//    - IDLE: search valid requesters from rr_ptr upward, wrapping modulo NUM_REQ.
//      - First hit i: req_ready[i]=1 for exactly that cycle; latch op/a/b/id.
//      - rr_ptr <= (i+1) mod NUM_REQ; go to DIV if op==0111, else EXEC.
//      - No valid requester: stay IDLE, req_ready=0.
//    - EXEC (1 cycle): alu_* driven from latches; capture alu_res into resp_res; -> RESP.
//    - DIV: restoring divide, 32 iterations over cycles DIV_1..DIV_32, then -> RESP.
//      - b==0: skip iterations, resp_res=32'hFFFF_FFFF, resp_nan=1, -> RESP next cycle.
//    - RESP: resp_valid=1, outputs stable until resp_valid&&resp_ready; then -> IDLE.
//  - Latency from grant to resp_valid: 2 cycles non-div; 34 cycles div (b!=0); 2 cycles div-by-0.
//  - Occupancy and handshake rules:
//    - One op in flight; req_ready=0 in EXEC/DIV/RESP.
//    - Requesters must hold valid/op/a/b until granted.
//    - resp_valid never drops without a handshake.
//  - Flags: zero/neg computed from the final resp_res; nan only from div-by-zero.
//  - Simultaneous: resp handshake and a new request in the same cycle.
//    - Next grant issues the cycle after (IDLE); no same-cycle reissue.
//  - alu_* hold the last latched values outside EXEC (no toggling when idle).
// CONFIGURATION
//  ALU_SCHED_STATS_EN defined:
//    - adds outputs stat_busy_cycles[31:0] and stat_div_count[31:0].
//    - stat_busy_cycles counts cycles state!=IDLE; stat_div_count counts div grants.
//    - Both wrap at 2^32 and clear on reset.
//  ALU_SCHED_STATS_EN undefined: no counters, ports absent.
// STRUCTURE
//  - Shared package alu_pkg:
//    - localparams for the 4-bit op codes (ALU_XOR..ALU_SHR, ALU_DIV=4'b0111).
//    - sched state enum encoding (IDLE, EXEC, DIV, RESP).
//    - DIV_CYCLES=32.
//  - Sub-module alu_div_iter:
//    - ports: start, a, b -> busy, done, q, div_by_zero.
//    - restoring unsigned divider, 32 cycles; instantiated once.
//  - Arbiter (rr pointer + wrap search) stays inline.
// TESTING
//  1. Single req0 add 5+7 -> req_ready[0] one cycle; resp_valid 2 cycles later; res=12, id=0, zero=0.
//  2. req0,req1 both valid, sub 3-3 and xor -> grants alternate 0,1,0.
//     - Flags/ids match: sub res=0, zero=1.
//  3. div 100/7 -> resp_valid 34 cycles after grant, res=14, nan=0.
//     - div 5/0 -> res=FFFF_FFFF, nan=1 in 2 cycles.
//  4. resp_ready held low 10 cycles -> resp stable, req_ready stays 0; release -> IDLE, next grant +1 cycle.
//  5. reset asserted at DIV_10 -> next cycle IDLE, resp_valid=0, rr_ptr=0; later req completes normally.
//  6. shl 1<<35 -> res=8 (b[4:0]=3); sub 0-1 -> res=FFFF_FFFF, neg=1.
//     - STATS_EN: busy count matches cycles spent.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, scheduler state encoding and latched request type.
package alu_pkg;
  localparam logic [3:0] ALU_XOR  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ANDN = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_DIV  = 4'b0111;
  localparam logic [3:0] ALU_SHL  = 4'b1000;
  localparam logic [3:0] ALU_SHR  = 4'b1001;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, RESP} sched_state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;
endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle; divide-by-zero
// finishes on the cycle after start with q = all ones.
module alu_div_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic        div_by_zero
);
  logic [31:0] rem, dvs;
  logic [5:0]  cnt;
  logic [32:0] shl, diff;

  // q doubles as the dividend shift register: dividend bits leave the top
  // while quotient bits enter the bottom.
  assign shl  = {rem, q[31]};
  assign diff = shl - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      q           <= '0;
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvs         <= b;
        rem         <= '0;
        div_by_zero <= (b == '0);
        if (b == '0) begin
          q    <= '1;
          done <= 1'b1;
          busy <= 1'b0;
          cnt  <= '0;
        end else begin
          q    <= a;
          busy <= 1'b1;
          cnt  <= 6'(DIV_CYCLES);
        end
      end else if (busy) begin
        q   <= {q[30:0], ~diff[32]};
        rem <= diff[32] ? shl[31:0] : diff[31:0];
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between NUM_REQ requesters, with an
// iterative divider. Optional counters under ALU_SCHED_STATS_EN.
module alu_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [3:0]            alu_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_res,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_res,
  output logic                  resp_zero,
  output logic                  resp_neg,
  output logic                  resp_nan
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_busy_cycles,
  output logic [31:0]           stat_div_count
`endif
);
  sched_state_e state;
  logic [ID_W-1:0] rr_ptr, gnt_idx, id_q;
  logic            gnt_any, gnt, cap;
  logic [NUM_REQ-1:0][3:0]  op_v;
  logic [NUM_REQ-1:0][31:0] a_v, b_v;
  alu_req_t        sel, cur;
  logic [31:0]     res_nxt, div_q;
  logic            div_start, div_busy, div_done, div_dbz;
  logic [ID_W:0]   cand;

  assign op_v = req_op;
  assign a_v  = req_a;
  assign b_v  = req_b;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign gnt = !reset && (state == IDLE) && !div_busy && gnt_any;

  always_comb begin
    req_ready = '0;
    if (gnt) req_ready[gnt_idx] = 1'b1;
  end

  assign sel.op    = op_v[gnt_idx];
  assign sel.a     = a_v[gnt_idx];
  assign sel.b     = b_v[gnt_idx];
  assign div_start = gnt && (sel.op == ALU_DIV);

  alu_div_iter u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (div_start),
    .a           (sel.a),
    .b           (sel.b),
    .busy        (div_busy),
    .done        (div_done),
    .q           (div_q),
    .div_by_zero (div_dbz)
  );

  // ALU sees the latched request only; it holds still between operations.
  assign alu_op  = cur.op;
  assign alu_a   = cur.a;
  assign alu_b   = cur.b;
  assign resp_id = id_q;

  assign cap     = (state == EXEC) || ((state == DIV) && div_done);
  assign res_nxt = (state == DIV) ? div_q : alu_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur        <= '0;
      id_q       <= '0;
      resp_valid <= 1'b0;
      resp_res   <= '0;
      resp_zero  <= 1'b0;
      resp_neg   <= 1'b0;
      resp_nan   <= 1'b0;
    end else if (cap) begin
      resp_res   <= res_nxt;
      resp_zero  <= (res_nxt == '0);
      resp_neg   <= res_nxt[31];
      resp_nan   <= (state == DIV) && div_dbz;
      resp_valid <= 1'b1;
      state      <= RESP;
    end else begin
      case (state)
        IDLE: if (gnt) begin
          cur    <= sel;
          id_q   <= gnt_idx;
          rr_ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
          state  <= (sel.op == ALU_DIV) ? DIV : EXEC;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_busy_cycles <= '0;
      stat_div_count   <= '0;
    end else begin
      if (state != IDLE) stat_busy_cycles <= stat_busy_cycles + 32'd1;
      if (div_start)     stat_div_count   <= stat_div_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed table, multi-cycle corner
// sequences and a randomized run against a cycle-level reference model.
module tb_alu_sched;
  import alu_pkg::*;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [3:0]            alu_op;
  logic [31:0]           alu_a, alu_b, alu_res;
  logic                  resp_valid, resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_res;
  logic                  resp_zero, resp_neg, resp_nan;
`ifdef ALU_SCHED_STATS_EN
  logic [31:0]           stat_busy_cycles, stat_div_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_res(resp_res), .resp_zero(resp_zero), .resp_neg(resp_neg),
    .resp_nan(resp_nan)
`ifdef ALU_SCHED_STATS_EN
    , .stat_busy_cycles(stat_busy_cycles), .stat_div_count(stat_div_count)
`endif
  );

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'd0:    return a ^ b;
      4'd1:    return a & b;
      4'd2:    return a | b;
      4'd3:    return a & ~b;
      4'd5:    return a - b;
      4'd6:    return a * b;
      4'd7:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd8:    return a << b[4:0];
      4'd9:    return a >> b[4:0];
      default: return a + b;
    endcase
  endfunction

  // External ALU stub; its divide output is poison so the scheduler must not use it.
  always_comb alu_res = (alu_op == ALU_DIV) ? 32'hDEAD_BEEF : ref_alu(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Waits for a grant, drops that request, waits for the response and checks it.
  task automatic serve(input string tag, input logic [NUM_REQ-1:0] exp_rdy,
                       input logic [31:0] exp_res, input int exp_lat,
                       input logic exp_nan, output int gw);
    logic [NUM_REQ-1:0] g;
    int c, eid;
`ifdef ALU_SCHED_STATS_EN
    logic [31:0] s_busy, s_div;
`endif
    g = '0; c = 0; eid = 0;
    for (int i = 0; i < NUM_REQ; i++) if (exp_rdy[i]) eid = i;
    while (g == '0 && c < 60) begin
      @(negedge clk);
      g = req_ready;
      c++;
    end
    gw = c;
    chk({tag, "/grant"}, 32'(g), 32'(exp_rdy));
    if (g == '0) return;
`ifdef ALU_SCHED_STATS_EN
    s_busy = stat_busy_cycles;
    s_div  = stat_div_count;
`endif
    @(posedge clk); #1;
    req_valid = req_valid & ~g;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!resp_valid && c < 100);
    chk({tag, "/latency"}, 32'(c), 32'(exp_lat));
    chk({tag, "/res"}, resp_res, exp_res);
    chk({tag, "/id"}, 32'(resp_id), 32'(eid));
    chk({tag, "/zero"}, 32'(resp_zero), 32'(exp_res == 0));
    chk({tag, "/neg"}, 32'(resp_neg), 32'(exp_res[31]));
    chk({tag, "/nan"}, 32'(resp_nan), 32'(exp_nan));
    @(posedge clk); #1;
`ifdef ALU_SCHED_STATS_EN
    chk({tag, "/stat_busy"}, stat_busy_cycles - s_busy, 32'(exp_lat));
    chk({tag, "/stat_div"}, stat_div_count - s_div, 32'((exp_lat == 34) || exp_nan));
`endif
  endtask

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    int          lat;
    logic        nan;
  } vec_t;

  function automatic vec_t mk(int id, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, int lat, logic nan);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat; v.nan = nan;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int gw, c, ptr, gcyc, lat_m, cyc, j, e_id;
    bit infl, e_rv;
    logic [NUM_REQ-1:0] e_rdy, g;
    logic [31:0] e_res, ra, rb;
    logic [3:0] rop;
    logic e_nan;

    tbl[0]  = mk(0, ALU_ADD,  32'd5,          32'd7,          32'd12,         2,  1'b0);
    tbl[1]  = mk(1, ALU_SUB,  32'd3,          32'd3,          32'd0,          2,  1'b0);
    tbl[2]  = mk(0, ALU_DIV,  32'd100,        32'd7,          32'd14,         34, 1'b0);
    tbl[3]  = mk(1, ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  2,  1'b1);
    tbl[4]  = mk(0, ALU_SHL,  32'd1,          32'd35,         32'd8,          2,  1'b0);
    tbl[5]  = mk(1, ALU_SUB,  32'd0,          32'd1,          32'hFFFF_FFFF,  2,  1'b0);
    tbl[6]  = mk(0, ALU_XOR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  2,  1'b0);
    tbl[7]  = mk(1, ALU_AND,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  2,  1'b0);
    tbl[8]  = mk(0, ALU_OR,   32'hF0F0_F0F0,  32'h0F0F_0F0F,  32'hFFFF_FFFF,  2,  1'b0);
    tbl[9]  = mk(1, ALU_ANDN, 32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_0000,  2,  1'b0);
    tbl[10] = mk(0, ALU_MUL,  32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  2,  1'b0);
    tbl[11] = mk(1, ALU_SHR,  32'h8000_0000,  32'd31,         32'd1,          2,  1'b0);
    tbl[12] = mk(0, 4'hF,     32'd2,          32'd3,          32'd5,          2,  1'b0);
    tbl[13] = mk(1, ALU_DIV,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 1'b0);
    tbl[14] = mk(0, ALU_DIV,  32'd3,          32'd10,         32'd0,          34, 1'b0);

    reset = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    chk("reset/req_ready_gated", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b0;
    @(negedge clk);
    chk("reset/resp_valid", 32'(resp_valid), 0);
    chk("reset/req_ready", 32'(req_ready), 0);
    chk("reset/resp_res", resp_res, 0);
    chk("reset/resp_id", 32'(resp_id), 0);
    chk("reset/flags", {29'd0, resp_zero, resp_neg, resp_nan}, 0);
    chk("reset/alu_op", 32'(alu_op), 0);
    chk("reset/alu_a", alu_a, 0);
    chk("reset/alu_b", alu_b, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      set_req(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
      serve($sformatf("vec%0d", i), NUM_REQ'(1 << tbl[i].id), tbl[i].res, tbl[i].lat, tbl[i].nan, gw);
    end

    // Both requesters valid: grants alternate 0, 1, 0.
    do_reset();
    set_req(0, ALU_SUB, 32'd3, 32'd3);
    set_req(1, ALU_XOR, 32'd5, 32'd6);
    serve("rr0", 2'b01, 32'd0, 2, 1'b0, gw);
    set_req(0, ALU_SUB, 32'd9, 32'd4);
    serve("rr1", 2'b10, 32'd3, 2, 1'b0, gw);
    serve("rr2", 2'b01, 32'd5, 2, 1'b0, gw);

    // Back-pressured response holds steady and blocks new grants.
    resp_ready = 1'b0;
    set_req(0, ALU_ADD, 32'd10, 32'd20);
    g = '0; c = 0;
    while (g == '0 && c < 20) begin @(negedge clk); g = req_ready; c++; end
    chk("hold/grant", 32'(g), 32'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, ALU_OR, 32'd1, 32'd2);
    c = 0;
    do begin @(negedge clk); c++; end while (!resp_valid && c < 20);
    chk("hold/latency", 32'(c), 2);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold/resp_valid", 32'(resp_valid), 1);
      chk("hold/resp_res", resp_res, 32'd30);
      chk("hold/req_ready", 32'(req_ready), 0);
    end
    chk("hold/alu_a", alu_a, 32'd10);
    chk("hold/alu_b", alu_b, 32'd20);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("hold/release_valid", 32'(resp_valid), 1);
    chk("hold/release_ready", 32'(req_ready), 0);
    serve("hold/next", 2'b10, 32'd3, 2, 1'b0, gw);
    chk("hold/next_wait", 32'(gw), 1);

    // Reset in the middle of a divide.
    set_req(0, ALU_DIV, 32'd1000, 32'd3);
    g = '0; c = 0;
    while (g == '0 && c < 20) begin @(negedge clk); g = req_ready; c++; end
    chk("rst/div_grant", 32'(g), 32'b01);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst/resp_valid", 32'(resp_valid), 0);
    chk("rst/resp_res", resp_res, 0);
    chk("rst/alu_a", alu_a, 0);
    @(posedge clk); #1;
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    set_req(0, ALU_DIV, 32'd1000, 32'd3);
    serve("rst/after0", 2'b01, 32'd333, 34, 1'b0, gw);
    serve("rst/after1", 2'b10, 32'd2, 2, 1'b0, gw);

    // Randomized traffic against a cycle-level reference model.
    do_reset();
    ptr = 0; infl = 0; cyc = 0; gcyc = 0; lat_m = 0; e_res = '0; e_id = 0; e_nan = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      e_rdy = '0;
      if (!infl)
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (ptr + k) % NUM_REQ;
          if (e_rdy == '0 && req_valid[j]) e_rdy[j] = 1'b1;
        end
      e_rv = infl && (cyc - gcyc >= lat_m);
      chk("rnd/req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rnd/resp_valid", 32'(resp_valid), 32'(e_rv));
      if (e_rv && resp_valid) begin
        chk("rnd/res", resp_res, e_res);
        chk("rnd/id", 32'(resp_id), 32'(e_id));
        chk("rnd/flags", {29'd0, resp_zero, resp_neg, resp_nan},
            {29'd0, e_res == 0, e_res[31], e_nan});
      end
      if (e_rdy != '0) begin
        for (int k = 0; k < NUM_REQ; k++) if (e_rdy[k]) j = k;
        rop   = req_op[4*j +: 4];
        ra    = req_a[32*j +: 32];
        rb    = req_b[32*j +: 32];
        e_res = ref_alu(rop, ra, rb);
        e_nan = (rop == ALU_DIV) && (rb == 0);
        lat_m = (rop == ALU_DIV && rb != 0) ? 34 : 2;
        e_id  = j;
        gcyc  = cyc;
        infl  = 1;
        ptr   = (j + 1) % NUM_REQ;
      end else if (e_rv && resp_ready) begin
        infl = 0;
      end
      cyc++;
      @(posedge clk); #1;
      req_valid = req_valid & ~e_rdy;
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          rb = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
          set_req(i, 4'($urandom_range(0, 15)), $urandom, rb);
        end
      resp_ready = ($urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
